// File: rtl/mac_array_unit.sv
// mac_array_unit: streaming matrix multiply C[M x N] = A[M x K] * B[K x N].
// Operands come from single-cycle-latency A/B memories. B is stored
// transposed, with LANES columns packed per word. Each output word carries
// LANES result columns and is written to the C memory.
//
// Optional build macro: MAC_ARRAY_SAT_EN. When it is defined, each lane
// saturates to the C_W range. When it is undefined, each lane wraps to its
// low C_W bits. Timing is the same in both builds.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle run request, accepted only while not busy
//   mode_signed       1 = two's-complement operands, latched at accepted start
//   a_b_re            A/B read enable; data returns on the following cycle
//   a_addr, b_addr    A element address (i*K+k), B word address (jg*K+k)
//   a_data_in         A element
//   b_data_in         LANES packed B elements
//   c_we, c_addr      C write strobe and word address (i*(N/LANES)+jg)
//   c_data_out        LANES packed results
//   busy, done        run in progress; one-cycle completion pulse
module mac_array_unit #(
    parameter int unsigned M     = 4,
    parameter int unsigned K     = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned LANES = 1,
    parameter int unsigned DW_IN = 8,
    parameter int unsigned C_W   = 2 * DW_IN,
    parameter int unsigned ACC_W = 2 * DW_IN + $clog2(K),
    localparam int unsigned NG   = N / LANES,
    localparam int unsigned A_AW = (M * K > 1) ? $clog2(M * K) : 1,
    localparam int unsigned B_AW = (K * NG > 1) ? $clog2(K * NG) : 1,
    localparam int unsigned C_AW = (M * NG > 1) ? $clog2(M * NG) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode_signed,
    output logic                   a_b_re,
    output logic [A_AW-1:0]        a_addr,
    output logic [B_AW-1:0]        b_addr,
    input  logic [DW_IN-1:0]       a_data_in,
    input  logic [LANES*DW_IN-1:0] b_data_in,
    output logic                   c_we,
    output logic [C_AW-1:0]        c_addr,
    output logic [LANES*C_W-1:0]   c_data_out,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned JW = (NG > 1) ? $clog2(NG) : 1;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic [IW-1:0]     i_q, i_d;
    logic [JW-1:0]     jg_q, jg_d;
    logic [KW-1:0]     k_q, k_d;
    logic [1:0]        drain_q;
    logic              mode_q;
    logic              a_b_re_q, busy_q, done_q;
    logic [A_AW-1:0]   a_addr_q, a_addr_d;
    logic [B_AW-1:0]   b_addr_q, b_addr_d;
    logic              last_issue;

    // Pipeline tags: stage 1 = operands arriving, stage 2 = products registered.
    logic              p1_v_q, p1_k0_q, p1_kl_q;
    logic              p2_v_q, p2_k0_q, p2_kl_q;
    logic [C_AW-1:0]   p1_ca_q, p2_ca_q;

    logic [LANES-1:0][ACC_W-1:0] prod_q, acc_q, acc_d;
    logic [LANES*C_W-1:0]        red_d, c_data_q;
    logic                        c_we_q;
    logic [C_AW-1:0]             c_addr_q;

    // Operand widening to the accumulator width.
    function automatic logic [ACC_W-1:0] extend_op(input logic [DW_IN-1:0] v, input logic sgn);
        if (sgn) return ACC_W'($signed(v));
        else     return ACC_W'(v);
    endfunction

    // Accumulator to stored-result reduction for one lane.
    function automatic logic [C_W-1:0] reduce_lane(input logic [ACC_W-1:0] acc, input logic sgn);
`ifdef MAC_ARRAY_SAT_EN
        logic [ACC_W-1:0] hi_u;
        logic [ACC_W-1:0] hi_s;
        hi_u = acc >> C_W;
        hi_s = ACC_W'($signed(acc) >>> (C_W - 1));
        if (sgn) begin
            // In range when every bit above the C_W sign bit copies the sign.
            if ((hi_s == '0) || (hi_s == '1)) return C_W'($signed(acc));
            else if (acc[ACC_W-1])            return {1'b1, {(C_W-1){1'b0}}};
            else                              return {1'b0, {(C_W-1){1'b1}}};
        end else begin
            if (hi_u == '0) return C_W'(acc);
            else            return '1;
        end
`else
        if (sgn) return C_W'($signed(acc));
        else     return C_W'(acc);
`endif
    endfunction

    // Next issue position (k inner, jg middle, i outer) and its addresses.
    always_comb begin
        i_d        = i_q;
        jg_d       = jg_q;
        k_d        = k_q;
        last_issue = (i_q == IW'(M - 1)) && (jg_q == JW'(NG - 1)) && (k_q == KW'(K - 1));
        if (k_q == KW'(K - 1)) begin
            k_d = '0;
            if (jg_q == JW'(NG - 1)) begin
                jg_d = '0;
                i_d  = i_q + IW'(1);
            end else begin
                jg_d = jg_q + JW'(1);
            end
        end else begin
            k_d = k_q + KW'(1);
        end
        a_addr_d = A_AW'(32'(i_d) * K + 32'(k_d));
        b_addr_d = B_AW'(32'(jg_d) * K + 32'(k_d));
    end

    // Control FSM: issue sequencing and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            jg_q     <= '0;
            k_q      <= '0;
            drain_q  <= '0;
            mode_q   <= 1'b0;
            a_b_re_q <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        a_b_re_q <= 1'b1;
                        mode_q   <= mode_signed;
                        i_q      <= '0;
                        jg_q     <= '0;
                        k_q      <= '0;
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                    end
                end
                S_RUN: begin
                    if (last_issue) begin
                        a_b_re_q <= 1'b0;
                        drain_q  <= '0;
                        state_q  <= S_DRAIN;
                    end else begin
                        i_q      <= i_d;
                        jg_q     <= jg_d;
                        k_q      <= k_d;
                        a_addr_q <= a_addr_d;
                        b_addr_q <= b_addr_d;
                    end
                end
                S_DRAIN: begin
                    // Three cycles let the last group reach the C write.
                    if (drain_q == 2'd2) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Accumulate: load on k=0, add otherwise; reduce the new value for write-out.
    always_comb begin
        acc_d = '0;
        red_d = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            acc_d[l] = p2_k0_q ? prod_q[l] : acc_q[l] + prod_q[l];
            red_d[l*C_W +: C_W] = reduce_lane(acc_d[l], mode_q);
        end
    end

    // Datapath pipeline: multiply, accumulate, write.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_v_q   <= 1'b0;
            p1_k0_q  <= 1'b0;
            p1_kl_q  <= 1'b0;
            p1_ca_q  <= '0;
            p2_v_q   <= 1'b0;
            p2_k0_q  <= 1'b0;
            p2_kl_q  <= 1'b0;
            p2_ca_q  <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            c_we_q   <= 1'b0;
            c_addr_q <= '0;
            c_data_q <= '0;
        end else begin
            p1_v_q  <= a_b_re_q;
            p1_k0_q <= (k_q == '0);
            p1_kl_q <= (k_q == KW'(K - 1));
            p1_ca_q <= C_AW'(32'(i_q) * NG + 32'(jg_q));
            p2_v_q  <= p1_v_q;
            p2_k0_q <= p1_k0_q;
            p2_kl_q <= p1_kl_q;
            p2_ca_q <= p1_ca_q;
            if (p1_v_q) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    prod_q[l] <= extend_op(a_data_in, mode_q) *
                                 extend_op(b_data_in[l*DW_IN +: DW_IN], mode_q);
                end
            end
            if (p2_v_q) begin
                acc_q <= acc_d;
            end
            c_we_q <= p2_v_q & p2_kl_q;
            if (p2_v_q && p2_kl_q) begin
                c_addr_q <= p2_ca_q;
                c_data_q <= red_d;
            end
        end
    end

    assign a_b_re     = a_b_re_q;
    assign a_addr     = a_addr_q;
    assign b_addr     = b_addr_q;
    assign c_we       = c_we_q;
    assign c_addr     = c_addr_q;
    assign c_data_out = c_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mac_array_unit.sv
// Bench for mac_array_unit: a default instance (LANES=1) and a LANES=2
// instance share clock and reset. Directed vectors are checked against
// hand-computed values and a small matrix-multiply reference.
module tb_mac_array_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start1, start2, mode1, mode2;
    logic        re1, re2, we1, we2, busy1, busy2, done1, done2;
    logic [3:0]  aaddr1, aaddr2, baddr1, caddr1;
    logic [2:0]  baddr2, caddr2;
    logic [7:0]  adata1, adata2, bdata1;
    logic [15:0] bdata2, cdata1;
    logic [31:0] cdata2;

    logic [7:0]  amem  [16];
    logic [7:0]  b1mem [16];
    logic [15:0] b2mem [8];

    mac_array_unit u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode_signed(mode1),
        .a_b_re(re1), .a_addr(aaddr1), .b_addr(baddr1),
        .a_data_in(adata1), .b_data_in(bdata1),
        .c_we(we1), .c_addr(caddr1), .c_data_out(cdata1),
        .busy(busy1), .done(done1)
    );

    mac_array_unit #(.LANES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode_signed(mode2),
        .a_b_re(re2), .a_addr(aaddr2), .b_addr(baddr2),
        .a_data_in(adata2), .b_data_in(bdata2),
        .c_we(we2), .c_addr(caddr2), .c_data_out(cdata2),
        .busy(busy2), .done(done2)
    );

    // Single-cycle-latency operand memories.
    always @(posedge clk) begin
        if (re1) begin
            adata1 <= amem[aaddr1];
            bdata1 <= b1mem[baddr1];
        end
    end
    always @(posedge clk) begin
        if (re2) begin
            adata2 <= amem[aaddr2];
            bdata2 <= b2mem[baddr2];
        end
    end

`ifdef MAC_ARRAY_SAT_EN
    localparam logic [15:0] FF_FF   = 16'hFFFF;
    localparam logic [15:0] MIN_MIN = 16'h7FFF;
`else
    localparam logic [15:0] FF_FF   = 16'hF804;
    localparam logic [15:0] MIN_MIN = 16'h0000;
`endif

    typedef struct {
        int          d;
        logic        sgn;
        int          pat;
        logic [7:0]  fa;
        logic [7:0]  fb;
        int          exp_wr;
        int          exp_re;
        int          exp_last;
        int          exp_done;
        logic [31:0] exp_w0;
        logic [31:0] exp_wl;
    } vec_t;

    vec_t        vecs [7];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] a_elem(input int pat, input logic [7:0] fa, input int x);
        if (pat == 0) return 8'(x);
        return fa;
    endfunction

    function automatic logic [7:0] b_elem(input int pat, input logic [7:0] fb, input int r, input int c);
        if (pat == 0) return 8'(4 * r + c);
        return fb;
    endfunction

    // Reference element C[i][j] with the build's reduction.
    function automatic logic [15:0] exp_c(input int pat, input logic [7:0] fa, input logic [7:0] fb,
                                          input logic sgn, input int i, input int j);
        longint s;
        logic [7:0] av, bv;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            av = a_elem(pat, fa, i * 4 + k);
            bv = b_elem(pat, fb, k, j);
            if (sgn) s += longint'($signed(av)) * longint'($signed(bv));
            else     s += longint'(av) * longint'(bv);
        end
`ifdef MAC_ARRAY_SAT_EN
        if (sgn) begin
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
        end else if (s > 65535) begin
            s = 65535;
        end
`endif
        return 16'(s);
    endfunction

    task automatic load(input int pat, input logic [7:0] fa, input logic [7:0] fb);
        for (int x = 0; x < 16; x++) amem[x] = a_elem(pat, fa, x);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b1mem[c * 4 + r] = b_elem(pat, fb, r, c);
        for (int jg = 0; jg < 2; jg++)
            for (int r = 0; r < 4; r++)
                b2mem[jg * 4 + r] = {b_elem(pat, fb, r, 2 * jg + 1), b_elem(pat, fb, r, 2 * jg)};
    endtask

    // Start one run and watch it until done (bounded); optional re-pulse / restart.
    task automatic run_job(input int d, input logic sgn, input int repulse_at, input bit restart,
                           output int nwr, output int nre, output int last_we, output int done_at);
        logic s_re, s_we, s_busy, s_done;
        logic [31:0] s_ca, s_cd;
        nwr = 0; nre = 0; last_we = -1; done_at = -1;
        @(negedge clk);
        if (d == 1) begin start1 = 1'b1; mode1 = sgn; end
        else        begin start2 = 1'b1; mode2 = sgn; end
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            start2 = 1'b0;
            if (n == repulse_at) begin
                if (d == 1) begin start1 = 1'b1; mode1 = ~sgn; end
                else        begin start2 = 1'b1; mode2 = ~sgn; end
            end
            if (d == 1) begin
                s_re = re1; s_we = we1; s_busy = busy1; s_done = done1;
                s_ca = 32'(caddr1); s_cd = 32'(cdata1);
            end else begin
                s_re = re2; s_we = we2; s_busy = busy2; s_done = done2;
                s_ca = 32'(caddr2); s_cd = cdata2;
            end
            if (n == 1) check("busy in cycle 1", 64'(s_busy), 64'd1);
            if (s_re) nre++;
            if (s_we) begin
                if (nwr < 16) begin
                    wr_addr[nwr] = s_ca;
                    wr_data[nwr] = s_cd;
                end
                nwr++;
                last_we = n;
            end
            if (s_done) begin
                done_at = n;
                check("busy in done cycle", 64'(s_busy), 64'd0);
                if (restart) begin
                    if (d == 1) start1 = 1'b1; else start2 = 1'b1;
                    @(negedge clk);
                    start1 = 1'b0;
                    start2 = 1'b0;
                    check("restart a_b_re", 64'(d == 1 ? re1 : re2), 64'd1);
                    check("restart busy", 64'(d == 1 ? busy1 : busy2), 64'd1);
                    check("restart done low", 64'(d == 1 ? done1 : done2), 64'd0);
                end
                break;
            end
        end
    endtask

    // Run one vector and compare every write plus timing.
    task automatic run_vec(input int idx, input vec_t v, input int repulse_at);
        int nwr, nre, last_we, done_at, lim;
        logic [31:0] want;
        load(v.pat, v.fa, v.fb);
        run_job(v.d, v.sgn, repulse_at, 1'b0, nwr, nre, last_we, done_at);
        check($sformatf("v%0d writes", idx), 64'(nwr), 64'(v.exp_wr));
        check($sformatf("v%0d a_b_re cycles", idx), 64'(nre), 64'(v.exp_re));
        check($sformatf("v%0d last c_we cycle", idx), 64'(last_we), 64'(v.exp_last));
        check($sformatf("v%0d done cycle", idx), 64'(done_at), 64'(v.exp_done));
        lim = (nwr < v.exp_wr) ? nwr : v.exp_wr;
        if (lim > 16) lim = 16;
        for (int w = 0; w < lim; w++) begin
            if (v.d == 1) want = {16'h0, exp_c(v.pat, v.fa, v.fb, v.sgn, w / 4, w % 4)};
            else want = {exp_c(v.pat, v.fa, v.fb, v.sgn, w / 2, 2 * (w % 2) + 1),
                         exp_c(v.pat, v.fa, v.fb, v.sgn, w / 2, 2 * (w % 2))};
            check($sformatf("v%0d c_addr[%0d]", idx, w), 64'(wr_addr[w]), 64'(w));
            check($sformatf("v%0d c_data[%0d]", idx, w), 64'(wr_data[w]), 64'(want));
        end
        if (lim > 0) begin
            check($sformatf("v%0d word0 hand", idx), 64'(wr_data[0]), 64'(v.exp_w0));
            check($sformatf("v%0d last word hand", idx), 64'(wr_data[lim - 1]), 64'(v.exp_wl));
        end
    endtask

    initial begin
        int nwr, nre, last_we, done_at, activity;

        vecs[0] = '{1, 1'b0, 0, 8'h00, 8'h00, 16, 64, 67, 68, 32'd56, 32'd506};
        vecs[1] = '{2, 1'b0, 0, 8'h00, 8'h00, 8, 32, 35, 36, 32'h003E_0038, 32'h01FA_01C4};
        vecs[2] = '{1, 1'b1, 1, 8'hFF, 8'h02, 16, 64, 67, 68, 32'hFFF8, 32'hFFF8};
        vecs[3] = '{1, 1'b0, 1, 8'hFF, 8'h02, 16, 64, 67, 68, 32'h07F8, 32'h07F8};
        vecs[4] = '{1, 1'b0, 1, 8'hFF, 8'hFF, 16, 64, 67, 68, {16'h0, FF_FF}, {16'h0, FF_FF}};
        vecs[5] = '{2, 1'b1, 1, 8'hFF, 8'h02, 8, 32, 35, 36, 32'hFFF8_FFF8, 32'hFFF8_FFF8};
        vecs[6] = '{1, 1'b1, 1, 8'h80, 8'h80, 16, 64, 67, 68, {16'h0, MIN_MIN}, {16'h0, MIN_MIN}};

        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode1 = 1'b0; mode2 = 1'b0;
        load(0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        check("reset a_b_re", 64'({re1, re2}), 64'd0);
        check("reset c_we", 64'({we1, we2}), 64'd0);
        check("reset busy/done (start held)", 64'({busy1, busy2, done1, done2}), 64'd0);
        check("reset c_data", 64'({cdata1, cdata2}), 64'd0);
        check("reset addrs", 64'({aaddr1, baddr1, caddr1, caddr2}), 64'd0);
        start1 = 1'b0;
        rst = 1'b0;

        for (int v = 0; v < 7; v++) run_vec(v, vecs[v], 0);

        // Start re-pulsed mid-RUN must not disturb the run.
        run_vec(10, vecs[0], 10);

        // Start in the done cycle begins a new run at once; then reset aborts it.
        load(0, 8'h00, 8'h00);
        run_job(1, 1'b0, 0, 1'b1, nwr, nre, last_we, done_at);
        check("restart first run done", 64'(done_at), 64'd68);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort a_b_re", 64'(re1), 64'd0);
        check("abort c_we", 64'(we1), 64'd0);
        check("abort busy", 64'(busy1), 64'd0);
        check("abort done", 64'(done1), 64'd0);
        activity = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (we1 || re1 || busy1 || done1) activity++;
        end
        check("no activity after abort", 64'(activity), 64'd0);

        // A fresh start after the abort runs normally.
        run_vec(11, vecs[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_array_unit.md
Name: mac_array_unit

Overview:
- Parametrised successor to the single-lane matrix MAC engine: computes C[M x N] = A[M x K] * B[K x N] by streaming operands from external single-cycle-latency memories and writing results back.
- Adds LANES parallel output columns per cycle, a runtime signed/unsigned mode, and a start/busy/done handshake. Sits between the A/B operand SRAMs and the C result SRAM in the matrix accelerator datapath.
- B memory holds B transposed, packed LANES columns per word.

Parameters:
- M, 4, rows of A and C
- K, 4, inner dimension
- N, 4, columns of B and C; must be a multiple of LANES
- LANES, 1, output columns computed in parallel (1, 2, 4, ...)
- DW_IN, 8, operand element width
- C_W, 2*DW_IN, stored result element width
- ACC_W, 2*DW_IN+$clog2(K), internal accumulator width; never overflows

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only when busy=0
- mode_signed  in  1  1 = two's-complement operands; latched at accepted start
- a_b_re  out  1  A/B read enable; data returns on a_data_in/b_data_in next cycle
- a_addr  out  $clog2(M*K)  A element address = i*K+k
- b_addr  out  $clog2(K*N/LANES)  B word address = jg*K+k (jg = column group)
- a_data_in  in  DW_IN  A element, valid the cycle after a_b_re
- b_data_in  in  LANES*DW_IN  lane l = Bt[jg*LANES+l][k] in bits [l*DW_IN +: DW_IN]
- c_we  out  1  C write enable
- c_addr  out  $clog2(M*N/LANES)  C word address = i*(N/LANES)+jg
- c_data_out  out  LANES*C_W  lane l = C[i][jg*LANES+l]
- busy  out  1  high from cycle after accepted start through last c_we
- done  out  1  one-cycle pulse the cycle after last c_we

Behaviour:
- Clock clk; reset rst is synchronous and active-high. While rst=1: all outputs 0, FSM to IDLE, counters and accumulators cleared, start ignored. Reset mid-operation aborts with no further writes.
- FSM: IDLE -> RUN on start; RUN -> DRAIN after last issue; DRAIN holds 3 cycles -> DONE; DONE (done=1, busy=0) -> IDLE next cycle. Start is accepted in IDLE and DONE; start while busy=1 is ignored.
- Issue order: i outer (0..M-1), jg middle (0..N/LANES-1), k inner (0..K-1). One read per cycle, back-to-back, no bubbles. a_b_re=1 exactly M*(N/LANES)*K cycles.
- Pipeline: issue at t; operands arrive at t+1 and the LANES products are registered at the end of t+1; accumulate at the end of t+2 (load when k=0, add otherwise); c_we/c_addr/c_data_out valid for one cycle at t+3 for the issue with k=K-1.
- Consecutive groups overlap with no stall; K=1 gives c_we every cycle.
- Latency: start sampled at edge 0, first a_b_re in cycle 1, last c_we in cycle T+3 with T = M*(N/LANES)*K, done in cycle T+4.
- Arithmetic: operands are sign- or zero-extended to ACC_W per the latched mode_signed; products are full 2*DW_IN. Result reduction ACC_W -> C_W is set by the optional feature.
- Addresses and c_data_out hold their last values when idle; c_data_out is don't-care when c_we=0 but never X after reset.

Optional Feature:
- Macro MAC_ARRAY_SAT_EN.
- Defined: each lane clamps to the C_W range (unsigned 0..2^C_W-1; signed -2^(C_W-1)..2^(C_W-1)-1).
- Undefined: each lane is truncated to the low C_W bits (wrap). Timing is identical in both builds.

Test Plan:
- Defaults, unsigned, A[x]=x, B[r][c]=4r+c stored transposed, start pulse -> c_we at c_addr 0..15 in order; C[0][0]=56, C[3][3]=506; a_b_re high 64 cycles; last c_we cycle 67, done cycle 68.
- LANES=2, same data -> 8 writes, c_addr 0..7; word 0 = {C[0][1]=62, C[0][0]=56}; done in cycle 36.
- mode_signed=1, all A=0xFF, all B=0x02 -> every C=0xFFF8 (-8); same data with mode_signed=0 -> 0x07F8.
- A=B=0xFF unsigned, C_W=16 -> with MAC_ARRAY_SAT_EN every C=0xFFFF; without it 0xF804.
- start re-pulsed mid-RUN -> ignored, output sequence unchanged; start in the done cycle -> new run starts, a_b_re high next cycle.
- rst=1 for one cycle mid-RUN -> next cycle a_b_re=c_we=busy=done=0; no further c_we until a new start.
